// File: rtl/input_port_buffer.sv
// Synchronised, stability-filtered input capture feeding a first-word-fall-through FIFO for the CPU input port.
// Optional INPUT_PORT_OVERWRITE_EN: a push into a full FIFO overwrites the oldest word instead of dropping the new one.
module input_port_buffer #(
  parameter int DATA_W        = 16,
  parameter int DEPTH         = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      ext_pin,
  input  logic                   ext_strobe,
  input  logic                   cpu_rd,
  input  logic                   ovf_clr,
  output logic [DATA_W-1:0]      input_pin,
  output logic                   input_enable,
  output logic                   full,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STABLE_CYCLES + 1);
`ifdef INPUT_PORT_OVERWRITE_EN
  localparam bit OVERWRITE = 1'b1;
`else
  localparam bit OVERWRITE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, PUSH} state_t;

  logic [DATA_W-1:0] pin_s1, pin_s2, snapshot;
  logic              stb_s1, stb_s2, stb_s3, rise_q;
  logic [SW-1:0]     stable_cnt;
  state_t            state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop, push_ok, drop, wr_en;
  logic [CW-1:0]     count_next;

  // Two-flop synchronisers; the strobe edge detect is registered so it is glitch-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pin_s1 <= '0;
      pin_s2 <= '0;
      stb_s1 <= 1'b0;
      stb_s2 <= 1'b0;
      stb_s3 <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      pin_s1 <= ext_pin;
      pin_s2 <= pin_s1;
      stb_s1 <= ext_strobe;
      stb_s2 <= stb_s1;
      stb_s3 <= stb_s2;
      rise_q <= stb_s2 & ~stb_s3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      snapshot   <= '0;
      stable_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (rise_q) begin
          snapshot   <= pin_s2;
          stable_cnt <= SW'(1);
          state      <= SETTLE;
        end
        SETTLE: if (pin_s2 != snapshot) begin
          snapshot   <= pin_s2;
          stable_cnt <= SW'(1);
        end else if (stable_cnt == SW'(STABLE_CYCLES)) begin
          state <= PUSH;
        end else begin
          stable_cnt <= stable_cnt + SW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A same-cycle pop frees a slot, so a push into a full FIFO still lands
  assign push       = (state == PUSH);
  assign pop        = cpu_rd & input_enable;
  assign push_ok    = push & (!full | pop);
  assign drop       = push & full & !pop;
  assign wr_en      = push_ok | (drop & OVERWRITE);
  assign count_next = count + CW'(push_ok) - CW'(pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= snapshot;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      input_enable <= 1'b0;
      full         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop | (drop & OVERWRITE)) rd_ptr <= rd_ptr + PW'(1);
      count        <= count_next;
      input_enable <= (count_next != '0);
      full         <= (count_next == CW'(DEPTH));
      if (drop) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign input_pin = input_enable ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_input_port_buffer.sv
// Scoreboard bench for input_port_buffer: directed captures queue expected words, a negedge monitor checks pops.
module tb_input_port_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ext_pin;
  logic        ext_strobe, cpu_rd, ovf_clr;
  logic [15:0] input_pin;
  logic        input_enable, full, overflow;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  input_port_buffer #(.DATA_W(16), .DEPTH(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .ext_pin(ext_pin), .ext_strobe(ext_strobe),
    .cpu_rd(cpu_rd), .ovf_clr(ovf_clr), .input_pin(input_pin),
    .input_enable(input_enable), .full(full), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 2 ns after the rising edge; outputs are checked there too
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic capture(input logic [15:0] w);
    ext_pin = w;
    step(3);
    ext_strobe = 1'b1;
    step(3);
    ext_strobe = 1'b0;
    step(12);
  endtask

  task automatic read_n(input int n);
    cpu_rd = 1'b1;
    step(n);
    cpu_rd = 1'b0;
    step(1);
  endtask

  // A pop happens at the next rising edge whenever cpu_rd and input_enable are both high
  always @(negedge clk) begin
    if (reset && cpu_rd && input_enable) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(input_pin), 32'hDEAD);
      end else begin
        chk("pop_data", 32'(input_pin), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; ext_pin = '0; ext_strobe = 1'b0; cpu_rd = 1'b0; ovf_clr = 1'b0;
    step(3);
    chk("rst_count", 32'(count), 0);
    chk("rst_enable", 32'(input_enable), 0);
    chk("rst_pin", 32'(input_pin), 0);
    reset = 1'b1;
    step(2);

    // 1: reset pulse while the FSM is settling discards the capture
    ext_pin = 16'hF0F0;
    step(3);
    ext_strobe = 1'b1;
    step(5);
    ext_strobe = 1'b0;
    reset = 1'b0;
    #1;
    chk("t1_enable_in_rst", 32'(input_enable), 0);
    chk("t1_full_in_rst", 32'(full), 0);
    chk("t1_ovf_in_rst", 32'(overflow), 0);
    #4;
    reset = 1'b1;
    step(20);
    chk("t1_no_word_enable", 32'(input_enable), 0);
    chk("t1_no_word_count", 32'(count), 0);

    // 2: latency from first strobe sample (edge N) to input_enable after edge N+8
    ext_strobe = 1'b1;
    exp_q.push_back(16'hF0F0);
    step(3);
    ext_strobe = 1'b0;
    step(5);
    chk("t2_enable_at_n7", 32'(input_enable), 0);
    step(1);
    chk("t2_enable_at_n8", 32'(input_enable), 1);
    chk("t2_pin_at_n8", 32'(input_pin), 16'hF0F0);
    read_n(1);
    chk("t2_enable_after_rd", 32'(input_enable), 0);
    chk("t2_count_after_rd", 32'(count), 0);

    // 3: bus toggling during settle; only the final stable value is captured
    ext_pin = 16'h1234;
    step(3);
    ext_strobe = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ext_pin = (i % 2 == 0) ? 16'h5678 : 16'h1234;
      if (i == 3) ext_strobe = 1'b0;
      step(1);
    end
    ext_pin = 16'h5678;
    exp_q.push_back(16'h5678);
    step(15);
    chk("t3_count_one", 32'(count), 1);
    read_n(1);
    chk("t3_count_zero", 32'(count), 0);

    // 4: five captures into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
`ifdef INPUT_PORT_OVERWRITE_EN
      if (i >= 2) exp_q.push_back(16'(i));
`else
      if (i <= 4) exp_q.push_back(16'(i));
`endif
      capture(16'(i));
    end
    chk("t4_full", 32'(full), 1);
    chk("t4_count", 32'(count), 4);
    chk("t4_overflow", 32'(overflow), 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("t4_ovf_cleared", 32'(overflow), 0);
    read_n(4);
    chk("t4_drained", 32'(count), 0);

    // 5: push into a full FIFO in the same cycle as a pop
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'h0011 + 16'(i));
      capture(16'h0011 + 16'(i));
    end
    chk("t5_full_before", 32'(full), 1);
    ext_pin = 16'h0015;
    exp_q.push_back(16'h0015);
    step(3);
    ext_strobe = 1'b1;
    step(3);
    ext_strobe = 1'b0;
    step(5);
    cpu_rd = 1'b1;
    step(1);
    cpu_rd = 1'b0;
    chk("t5_count_stays", 32'(count), 4);
    chk("t5_no_overflow", 32'(overflow), 0);
    step(10);
    chk("t5_count_settled", 32'(count), 4);
    read_n(4);
    chk("t5_drained", 32'(count), 0);

    // 6: read while empty is ignored, then a normal capture
    cpu_rd = 1'b1;
    step(1);
    cpu_rd = 1'b0;
    step(1);
    chk("t6_count_empty", 32'(count), 0);
    chk("t6_enable_empty", 32'(input_enable), 0);
    chk("t6_pin_empty", 32'(input_pin), 0);
    exp_q.push_back(16'hABCD);
    capture(16'hABCD);
    chk("t6_pin_head", 32'(input_pin), 16'hABCD);
    read_n(1);
    chk("t6_count_end", 32'(count), 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
